// File: rtl/gray_to_bin_tracker.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_bin_tracker
// Description : Decodes a Gray-coded count to registered binary, classifies
//               each valid step as up/down/illegal and counts illegal steps.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_to_bin_tracker #(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     g_num,
    input  logic                 g_valid,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     b_out,
    output logic                 b_valid,
    output logic                 up,
    output logic                 down,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [WIDTH-1:0]     c_DELTA_ZERO = '0;
    localparam logic [WIDTH-1:0]     c_DELTA_UP   = WIDTH'(1);
    localparam logic [WIDTH-1:0]     c_DELTA_DOWN = '1;
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX    = '1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       b_out_q, b_out_d;
    logic                   b_valid_q, b_valid_d;
    logic                   up_q, up_d;
    logic                   down_q, down_d;
    logic                   step_err_q, step_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]       w_bin;
    logic [WIDTH-1:0]       w_delta;
    logic [ERR_CNT_W-1:0]   w_err_base;

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_decode
        assign w_bin[i] = ^g_num[WIDTH-1:i];
    end

    // b_out_q doubles as the previous-sample reference.
    assign w_delta = w_bin - b_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            b_out_q    <= '0;
            b_valid_q  <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            b_out_q    <= b_out_d;
            b_valid_q  <= b_valid_d;
            up_q       <= up_d;
            down_q     <= down_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        b_out_d    = b_out_q;
        b_valid_d  = 1'b0;
        up_d       = 1'b0;
        down_d     = 1'b0;
        step_err_d = 1'b0;

        if (g_valid) begin
            b_out_d   = w_bin;
            b_valid_d = 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    // Up is tested first so a 1-bit count reports every change as up.
                    if (w_delta == c_DELTA_ZERO) begin
                        up_d = 1'b0;
                    end else if (w_delta == c_DELTA_UP) begin
                        up_d = 1'b1;
                    end else if (w_delta == c_DELTA_DOWN) begin
                        down_d = 1'b1;
                    end else begin
                        step_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Clear takes effect before a coincident error is counted.
    always_comb begin
        w_err_base = clr_err ? '0 : err_cnt_q;
        err_cnt_d  = w_err_base;
        if (step_err_d && (w_err_base != c_ERR_MAX)) begin
            err_cnt_d = w_err_base + ERR_CNT_W'(1);
        end
    end

    assign b_out    = b_out_q;
    assign b_valid  = b_valid_q;
    assign up       = up_q;
    assign down     = down_q;
    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_bin_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_to_bin_tracker
// Description : Directed self-checking bench for gray_to_bin_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_to_bin_tracker;

    logic       clk;
    logic       rst;
    logic [2:0] g_num;
    logic       g_valid;
    logic       clr_err;
    logic [2:0] b_out;
    logic       b_valid;
    logic       up;
    logic       down;
    logic       step_err;
    logic [3:0] err_cnt;

    int checks = 0;
    int errors = 0;

    gray_to_bin_tracker #(
        .WIDTH     (3),
        .ERR_CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .g_num    (g_num),
        .g_valid  (g_valid),
        .clr_err  (clr_err),
        .b_out    (b_out),
        .b_valid  (b_valid),
        .up       (up),
        .down     (down),
        .step_err (step_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {b_out, b_valid, up, down, step_err, err_cnt}
    task automatic chk(input string tag, input logic [2:0] eb, input logic ev,
                       input logic eu, input logic ed, input logic ee,
                       input logic [3:0] ec);
        logic [10:0] obs;
        logic [10:0] exp_v;
        obs   = {b_out, b_valid, up, down, step_err, err_cnt};
        exp_v = {eb, ev, eu, ed, ee, ec};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed b/v/u/d/e/cnt=%h/%b/%b/%b/%b/%h expected=%h/%b/%b/%b/%b/%h",
                   tag, obs[10:8], obs[7], obs[6], obs[5], obs[4], obs[3:0],
                   eb, ev, eu, ed, ee, ec);
        end
    endtask

    task automatic drive(input logic [2:0] g, input logic v, input logic c);
        @(negedge clk);
        g_num   = g;
        g_valid = v;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] gray_seq [8];
        logic [3:0] ec;
        gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        rst     = 1'b0;
        g_num   = '0;
        g_valid = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 3'd0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full ascending Gray sequence
        for (int i = 0; i < 8; i++) begin
            drive(gray_seq[i], 1'b1, 1'b0);
            chk($sformatf("seq%0d", i), 3'(i), 1, (i != 0), 0, 0, 4'd0);
        end

        drive(3'b000, 1'b1, 1'b0);
        chk("wrap_up", 3'd0, 1, 1, 0, 0, 4'd0);
        drive(3'b100, 1'b1, 1'b0);
        chk("wrap_down", 3'd7, 1, 0, 1, 0, 4'd0);
        drive(3'b101, 1'b1, 1'b0);
        chk("down_6", 3'd6, 1, 0, 1, 0, 4'd0);
        drive(3'b101, 1'b1, 1'b0);
        chk("repeat_6", 3'd6, 1, 0, 0, 0, 4'd0);
        drive(3'b100, 1'b1, 1'b0);
        chk("up_7", 3'd7, 1, 1, 0, 0, 4'd0);
        drive(3'b000, 1'b1, 1'b0);
        chk("up_0", 3'd0, 1, 1, 0, 0, 4'd0);

        drive(3'b011, 1'b1, 1'b0);
        chk("jump_2", 3'd2, 1, 0, 0, 1, 4'd1);
        drive(3'b010, 1'b1, 1'b0);
        chk("resync_3", 3'd3, 1, 1, 0, 0, 4'd1);

        // 17 illegal jumps alternating bin 0 / bin 4; counter saturates at 15
        ec = 4'd1;
        for (int i = 0; i < 17; i++) begin
            if (ec != 4'd15) ec = ec + 4'd1;
            drive((i % 2 == 0) ? 3'b000 : 3'b110, 1'b1, 1'b0);
            chk($sformatf("sat%0d", i), (i % 2 == 0) ? 3'd0 : 3'd4, 1, 0, 0, 1, ec);
        end

        drive(3'b110, 1'b1, 1'b1);
        chk("clr_with_err", 3'd4, 1, 0, 0, 1, 4'd1);
        drive(3'b000, 1'b0, 1'b1);
        chk("clr_alone", 3'd4, 0, 0, 0, 0, 4'd0);

        drive(3'b011, 1'b1, 1'b0);
        chk("jump_4_to_2", 3'd2, 1, 0, 0, 1, 4'd1);

        // Gap: invalid samples with changing g_num must not disturb state
        for (int i = 0; i < 5; i++) begin
            drive(3'(i + 3), 1'b0, 1'b0);
            chk($sformatf("gap%0d", i), 3'd2, 0, 0, 0, 0, 4'd1);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", 3'd0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        drive(3'b110, 1'b1, 1'b0);
        chk("first_after_rst", 3'd4, 1, 0, 0, 0, 4'd0);
        drive(3'b111, 1'b1, 1'b0);
        chk("up_after_rst", 3'd5, 1, 1, 0, 0, 4'd0);
        drive(3'b111, 1'b0, 1'b0);
        chk("pulse_drop", 3'd5, 0, 0, 0, 0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
